// File: rtl/vector_gather_unit.sv
// vector_gather_unit: SpMV front end. Issues one vector RAM gather per
// non-zero beat, holds the matrix values in an in-order pending FIFO and
// pairs them with the returned x[col] lanes.
// Ports: in_* non-zero beats (valid/ready), vr_* vector RAM read client,
//        out_* paired {val, x} beats (valid/ready), rows_done count of
//        delivered row-end beats, err sticky response-without-request flag.
module vector_gather_unit #(
   parameter int PARALLELISM = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int PEND_DEPTH  = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [PARALLELISM*ADDR_WIDTH-1:0] in_col,
   input  logic [PARALLELISM*DATA_WIDTH-1:0] in_val,
   input  logic [PARALLELISM-1:0]            in_mask,
   input  logic                              in_last,
   output logic                              vr_valid,
   input  logic                              vr_ready,
   output logic                              vr_write,
   output logic [PARALLELISM*ADDR_WIDTH-1:0] vr_addr,
   input  logic                              vr_rvalid,
   output logic                              vr_rready,
   input  logic [PARALLELISM*DATA_WIDTH-1:0] vr_rdata,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [PARALLELISM*DATA_WIDTH-1:0] out_val,
   output logic [PARALLELISM*DATA_WIDTH-1:0] out_x,
   output logic [PARALLELISM-1:0]            out_mask,
   output logic                              out_last,
   output logic [31:0]                       rows_done,
   output logic                              err
);
   localparam int P  = PARALLELISM;
   localparam int DW = DATA_WIDTH;
   localparam int AW = ADDR_WIDTH;
   localparam int IW = $clog2(PEND_DEPTH);
   localparam int PW = IW + 1;

   typedef struct packed {
      logic [P*DW-1:0] val;
      logic [P-1:0]    mask;
      logic            last;
   } pend_t;

   pend_t           mem [PEND_DEPTH];
   pend_t           head;
   logic [PW-1:0]   wptr;
   logic [PW-1:0]   rptr;
   logic            pend_full;
   logic            pend_empty;
   logic            push;
   logic            load;
   logic [P*DW-1:0] x_masked;

   // Extra pointer MSB separates full from empty without a counter.
   assign pend_empty = (wptr == rptr);
   assign pend_full  = (wptr[IW] != rptr[IW]) &&
                       (wptr[IW-1:0] == rptr[IW-1:0]);

   // The RAM request and the FIFO push are the same handshake.
   assign vr_valid  = in_valid && !pend_full;
   assign in_ready  = vr_ready && !pend_full;
   assign vr_write  = 1'b0;
   assign push      = in_valid && in_ready;

   // A response is only taken when a request is pending and the
   // output slot is free or draining this cycle.
   assign vr_rready = !pend_empty && (!out_valid || out_ready);
   assign load      = vr_rvalid && vr_rready;
   assign head      = mem[rptr[IW-1:0]];

   always_comb begin
      vr_addr  = '0;
      x_masked = '0;
      for (int i = 0; i < P; i++) begin
         if (in_mask[i])
            vr_addr[i*AW +: AW] = in_col[i*AW +: AW];
         if (head.mask[i])
            x_masked[i*DW +: DW] = vr_rdata[i*DW +: DW];
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wptr[IW-1:0]] <= {in_val, in_mask, in_last};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push)
            wptr <= wptr + PW'(1);
         if (load)
            rptr <= rptr + PW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_val   <= '0;
         out_x     <= '0;
         out_mask  <= '0;
         out_last  <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_val   <= head.val;
         out_x     <= x_masked;
         out_mask  <= head.mask;
         out_last  <= head.last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rows_done <= '0;
         err       <= 1'b0;
      end else begin
         if (out_valid && out_ready && out_last)
            rows_done <= rows_done + 32'd1;
         if (vr_rvalid && pend_empty)
            err <= 1'b1;
      end
   end

endmodule
